// File: rtl/knn_distance_if.sv
// Bus bundle for the KNN distance stage: control pulse, dictionary write
// port, pixel valid/ready handshake and the classifier-facing outputs.
interface knn_distance_if;
  logic        start;
  logic        dic_wr_en;
  logic [2:0]  dic_wr_addr;
  logic [15:0] dic_wr_data;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic [13:0] distance;
  logic [2:0]  m;
  logic        dic_go;
  logic        dic_end;
  logic        dic_end_q;
  logic        knn_fin;
  logic        busy;

  // Producer side: drives control, dictionary and pixels, observes results.
  modport master (
    output start, dic_wr_en, dic_wr_addr, dic_wr_data, pix_valid, pix_data,
    input  pix_ready, distance, m, dic_go, dic_end, dic_end_q, knn_fin, busy
  );

  // Distance stage side.
  modport slave (
    input  start, dic_wr_en, dic_wr_addr, dic_wr_data, pix_valid, pix_data,
    output pix_ready, distance, m, dic_go, dic_end, dic_end_q, knn_fin, busy
  );
endinterface

// File: rtl/knn_distance.sv
// KNN distance stage: holds an RGB565 colour dictionary, accepts knn pixels
// per block and, for each pixel, sweeps the dictionary one entry per cycle
// emitting the squared Euclidean distance and entry index, followed by the
// end-of-sweep flag pair and an idle gap cycle. After knn pixels the block
// completion level knn_fin is raised until a qualifying start.
// All outputs are flops loaded from the value they must show in the state
// being entered, so the observable timing equals a state-decoded Moore
// machine while keeping every output registered.
module knn_distance #(
  parameter int knn       = 4,
  parameter int color_num = 5
) (
  input  logic           clk_en,
  input  logic           reset_n,
  knn_distance_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PIX = 3'd1,
    S_SWEEP    = 3'd2,
    S_END_A    = 3'd3,
    S_END_B    = 3'd4,
    S_GAP      = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam logic [2:0] LAST_K  = 3'(color_num - 1);
  localparam logic [5:0] KNN_CNT = 6'(knn);
  // knn_fin is high for fin_age+1 cycles when start is taken, so the
  // downstream max scan gets at least color_num+2 cycles.
  localparam logic [3:0] FIN_MIN = 4'(color_num + 1);
  localparam logic [3:0] FIN_SAT = 4'hF;

  // Squared Euclidean distance between two RGB565 colours (max 5891).
  function automatic logic [13:0] sq_dist(input logic [15:0] pix,
                                          input logic [15:0] ent);
    logic [4:0]  dr;
    logic [5:0]  dg;
    logic [4:0]  db;
    logic [9:0]  r2;
    logic [11:0] g2;
    logic [9:0]  b2;
    dr = (pix[15:11] >= ent[15:11]) ? (pix[15:11] - ent[15:11])
                                    : (ent[15:11] - pix[15:11]);
    dg = (pix[10:5] >= ent[10:5]) ? (pix[10:5] - ent[10:5])
                                  : (ent[10:5] - pix[10:5]);
    db = (pix[4:0] >= ent[4:0]) ? (pix[4:0] - ent[4:0])
                                : (ent[4:0] - pix[4:0]);
    r2 = {5'd0, dr} * {5'd0, dr};
    g2 = {6'd0, dg} * {6'd0, dg};
    b2 = {5'd0, db} * {5'd0, db};
    sq_dist = {4'd0, r2} + {2'd0, g2} + {4'd0, b2};
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [5:0]  pix_cnt_q, pix_cnt_d;
  logic [3:0]  fin_age_q, fin_age_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] dict_q [color_num];
  logic [15:0] dict_d [color_num];

  logic        pix_ready_q, pix_ready_d;
  logic [13:0] distance_q, distance_d;
  logic [2:0]  m_q, m_d;
  logic        dic_go_q, dic_go_d;
  logic        end_flag_q, end_flag_d;
  logic        end_dly_q, end_dly_d;
  logic        knn_fin_q, knn_fin_d;
  logic        busy_q, busy_d;

  logic        wr_allowed;
  logic [15:0] entry_sel;

  // Dictionary next value: writes land only while idle or done, and an
  // out-of-range address matches no entry so it is silently dropped.
  always_comb begin
    wr_allowed = bus.dic_wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));
    for (int i = 0; i < color_num; i++) begin
      if (wr_allowed && (bus.dic_wr_addr == 3'(i))) begin
        dict_d[i] = bus.dic_wr_data;
      end else begin
        dict_d[i] = dict_q[i];
      end
    end
  end

  // Sequencer next state: block start, pixel accept, sweep, flags, gap, done.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pix_cnt_d = pix_cnt_q;
    fin_age_d = fin_age_q;
    pix_d     = pix_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_WAIT_PIX;
          pix_cnt_d = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_PIX: begin
        if (bus.pix_valid) begin
          pix_d   = bus.pix_data;
          k_d     = 3'd0;
          state_d = S_SWEEP;
        end else begin
          state_d = S_WAIT_PIX;
        end
      end
      S_SWEEP: begin
        if (k_q == LAST_K) begin
          state_d = S_END_A;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_END_A: state_d = S_END_B;
      S_END_B: state_d = S_GAP;
      S_GAP: begin
        pix_cnt_d = pix_cnt_q + 6'd1;
        if (pix_cnt_d == KNN_CNT) begin
          state_d   = S_DONE;
          fin_age_d = 4'd0;
        end else begin
          state_d = S_WAIT_PIX;
        end
      end
      S_DONE: begin
        if (bus.start && (fin_age_q >= FIN_MIN)) begin
          state_d   = S_WAIT_PIX;
          pix_cnt_d = 6'd0;
        end else if (fin_age_q != FIN_SAT) begin
          fin_age_d = fin_age_q + 4'd1;
        end else begin
          fin_age_d = fin_age_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered; sweep reads the entry at k_d.
  always_comb begin
    entry_sel = 16'h0000;
    for (int i = 0; i < color_num; i++) begin
      if (k_d == 3'(i)) begin
        entry_sel = dict_q[i];
      end else begin
        entry_sel = entry_sel;
      end
    end
    pix_ready_d = (state_d == S_WAIT_PIX);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    knn_fin_d   = (state_d == S_DONE);
    dic_go_d    = 1'b0;
    end_flag_d  = 1'b0;
    end_dly_d   = 1'b0;
    m_d         = 3'd0;
    distance_d  = 14'd0;
    case (state_d)
      S_SWEEP: begin
        dic_go_d   = 1'b1;
        m_d        = k_d;
        distance_d = sq_dist(pix_d, entry_sel);
      end
      S_END_A: begin
        dic_go_d   = 1'b1;
        end_flag_d = 1'b1;
        m_d        = m_q;
        distance_d = distance_q;
      end
      S_END_B: begin
        dic_go_d   = 1'b1;
        end_flag_d = 1'b1;
        end_dly_d  = 1'b1;
        m_d        = m_q;
        distance_d = distance_q;
      end
      default: begin
        dic_go_d = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      k_q       <= 3'd0;
      pix_cnt_q <= 6'd0;
      fin_age_q <= 4'd0;
      pix_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pix_cnt_q <= pix_cnt_d;
      fin_age_q <= fin_age_d;
      pix_q     <= pix_d;
    end
  end

  // Dictionary storage, cleared on reset.
  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < color_num; i++) begin
        dict_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < color_num; i++) begin
        dict_q[i] <= dict_d[i];
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_en or negedge reset_n) begin
    if (!reset_n) begin
      pix_ready_q <= 1'b0;
      distance_q  <= 14'd0;
      m_q         <= 3'd0;
      dic_go_q    <= 1'b0;
      end_flag_q  <= 1'b0;
      end_dly_q   <= 1'b0;
      knn_fin_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pix_ready_q <= pix_ready_d;
      distance_q  <= distance_d;
      m_q         <= m_d;
      dic_go_q    <= dic_go_d;
      end_flag_q  <= end_flag_d;
      end_dly_q   <= end_dly_d;
      knn_fin_q   <= knn_fin_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.distance  = distance_q;
  assign bus.m         = m_q;
  assign bus.dic_go    = dic_go_q;
  assign bus.dic_end   = end_flag_q;
  assign bus.dic_end_q = end_dly_q;
  assign bus.knn_fin   = knn_fin_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_knn_distance.sv
// Self-checking bench for knn_distance: a queue-based reference model of the
// observable output stream, compared every cycle, plus literal expectations.
module tb_knn_distance;
  localparam int KNN = 4;
  localparam int C   = 5;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_SWEEP = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  knn_distance_if bus();
  knn_distance #(.knn(KNN), .color_num(C)) dut (
    .clk_en  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int both_cnt = 0;

  typedef struct {
    bit go;
    bit de;
    bit deq;
    int m;
    int d;
  } rec_t;

  rec_t        sq[$];
  int          phase;
  int          npix;
  int          fin_age;
  logic [15:0] mdict [C];

  function automatic int ref_dist(logic [15:0] p, logic [15:0] e);
    int dr, dg, db, pr, pg, pb, er, eg, eb;
    pr = p[15:11]; pg = p[10:5]; pb = p[4:0];
    er = e[15:11]; eg = e[10:5]; eb = e[4:0];
    dr = pr - er; dg = pg - eg; db = pb - eb;
    return dr * dr + dg * dg + db * db;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    phase   = P_IDLE;
    npix    = 0;
    fin_age = 0;
    for (int i = 0; i < C; i++) mdict[i] = 16'h0000;
  endtask

  task automatic model_step();
    rec_t r;
    int   last_d;
    if (bus.dic_wr_en && (phase == P_IDLE || phase == P_DONE) && bus.dic_wr_addr < C)
      mdict[bus.dic_wr_addr] = bus.dic_wr_data;
    case (phase)
      P_IDLE: if (bus.start) begin phase = P_WAIT; npix = 0; end
      P_WAIT: if (bus.pix_valid) begin
        for (int k = 0; k < C; k++) begin
          r.go = 1; r.de = 0; r.deq = 0; r.m = k; r.d = ref_dist(bus.pix_data, mdict[k]);
          sq.push_back(r);
        end
        last_d = r.d;
        r.go = 1; r.de = 1; r.deq = 0; r.m = C - 1; r.d = last_d; sq.push_back(r);
        r.deq = 1; sq.push_back(r);
        r.go = 0; r.de = 0; r.deq = 0; r.m = 0; r.d = 0; sq.push_back(r);
        npix++;
        phase = P_SWEEP;
      end
      P_SWEEP: begin
        void'(sq.pop_front());
        if (sq.size() == 0) begin
          if (npix == KNN) begin phase = P_DONE; fin_age = 0; end
          else phase = P_WAIT;
        end
      end
      P_DONE: begin
        if (bus.start && fin_age >= C + 1) begin phase = P_WAIT; npix = 0; end
        else fin_age++;
      end
      default: phase = P_IDLE;
    endcase
  endtask

  // Reference model advances on each active edge, resets asynchronously.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every falling edge outside reset.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (phase == P_SWEEP) e = sq[0];
        else begin e.go = 0; e.de = 0; e.deq = 0; e.m = 0; e.d = 0; end
        chk("pix_ready", bus.pix_ready, (phase == P_WAIT) ? 1 : 0);
        chk("busy", bus.busy, (phase == P_WAIT || phase == P_SWEEP) ? 1 : 0);
        chk("knn_fin", bus.knn_fin, (phase == P_DONE) ? 1 : 0);
        chk("dic_go", bus.dic_go, e.go);
        chk("dic_end", bus.dic_end, e.de);
        chk("dic_end_q", bus.dic_end_q, e.deq);
        chk("m", bus.m, e.m);
        chk("distance", bus.distance, e.d);
        if (bus.dic_end && bus.dic_end_q) both_cnt++;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [2:0] a, logic [15:0] d);
    bus.dic_wr_en = 1'b1; bus.dic_wr_addr = a; bus.dic_wr_data = d;
    tick(1);
    bus.dic_wr_en = 1'b0;
  endtask

  // Returns one tick after the handshake edge, i.e. in the k=0 cycle.
  task automatic send_pixel(logic [15:0] p, int gap);
    logic r;
    int   ok;
    tick(gap);
    bus.pix_valid = 1'b1; bus.pix_data = p;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk); r = bus.pix_ready;
      @(posedge clk); #1;
      if (r) ok = 1;
    end
    bus.pix_valid = 1'b0;
    chk("pix_handshake_timeout", ok, 1);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_pix_ready"}, bus.pix_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_knn_fin"}, bus.knn_fin, 0);
    chk({tag, "_dic_go"}, bus.dic_go, 0);
    chk({tag, "_dic_end"}, bus.dic_end, 0);
    chk({tag, "_dic_end_q"}, bus.dic_end_q, 0);
    chk({tag, "_m"}, bus.m, 0);
    chk({tag, "_distance"}, bus.distance, 0);
  endtask

  initial begin
    int lit1 [C];
    int base;
    lit1 = '{961, 4930, 0, 4930, 1922};
    bus.start = 1'b0; bus.dic_wr_en = 1'b0; bus.dic_wr_addr = 3'd0;
    bus.dic_wr_data = 16'h0000; bus.pix_valid = 1'b0; bus.pix_data = 16'h0000;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1; reset_n = 1'b1;

    // Block 1: dictionary load, last entry written together with start.
    wr(3'd0, 16'h0000); wr(3'd1, 16'hFFFF); wr(3'd2, 16'hF800); wr(3'd3, 16'h07E0);
    wr(3'd5, 16'hAAAA);
    bus.start = 1'b1; bus.dic_wr_en = 1'b1; bus.dic_wr_addr = 3'd4; bus.dic_wr_data = 16'h001F;
    tick(1);
    bus.start = 1'b0; bus.dic_wr_en = 1'b0;
    base = both_cnt;

    send_pixel(16'hF800, 0);
    for (int k = 0; k < C; k++) begin
      chk("p1_m", bus.m, k);
      chk("p1_distance", bus.distance, lit1[k]);
      tick(1);
    end
    chk("p1_enda_end", bus.dic_end, 1); chk("p1_enda_endq", bus.dic_end_q, 0);
    chk("p1_enda_m", bus.m, 4); chk("p1_enda_d", bus.distance, 1922);
    tick(1);
    chk("p1_endb_end", bus.dic_end, 1); chk("p1_endb_endq", bus.dic_end_q, 1);
    tick(1);
    chk("p1_gap_go", bus.dic_go, 0); chk("p1_gap_d", bus.distance, 0);

    send_pixel(16'h0000, 0);
    tick(1);
    chk("max_distance", bus.distance, 5891);

    send_pixel(16'hFFFF, 3);
    tick(1);
    chk("zero_distance", bus.distance, 0);
    bus.dic_wr_en = 1'b1; bus.dic_wr_addr = 3'd2; bus.dic_wr_data = 16'h1234; bus.start = 1'b1;
    tick(1);
    bus.dic_wr_en = 1'b0; bus.start = 1'b0;

    send_pixel(16'hF800, 0);
    tick(2);
    chk("old_entry2", bus.distance, 0);
    tick(6);
    chk("done_fin", bus.knn_fin, 1);
    chk("both_high_cycles", both_cnt - base, 4);

    // Early start is ignored, a start after 7 DONE cycles is taken.
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    chk("early_start_fin", bus.knn_fin, 1);
    tick(5);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    chk("restart_fin", bus.knn_fin, 0);
    chk("restart_ready", bus.pix_ready, 1);

    // Block 2: four back-to-back pixels, counter starts from zero.
    send_pixel(16'h001F, 0);
    send_pixel(16'h07E0, 0);
    send_pixel(16'hF800, 0);
    send_pixel(16'h0000, 0);
    tick(8);
    chk("blk2_fin", bus.knn_fin, 1);
    tick(7);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;

    // Block 3: reset in the middle of a sweep.
    send_pixel(16'hF800, 0);
    tick(2);
    chk("pre_reset_m", bus.m, 2);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("post_reset_ready", bus.pix_ready, 0);
    chk("post_reset_busy", bus.busy, 0);

    // Cleared dictionary: every entry gives |pixel|^2.
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    send_pixel(16'h07E0, 0);
    for (int k = 0; k < C; k++) begin
      chk("cleared_distance", bus.distance, 3969);
      tick(1);
    end
    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/knn_distance.md
Name: knn_distance

Overview:
- Upstream distance stage for the KNN colour classifier; drives the classifier stage's distance, m, dic_go, dic_end, dic_end_q and knn_fin inputs.
- Holds a colour_num-entry RGB565 colour dictionary.
- Accepts knn RGB565 pixels per block through a valid/ready handshake.
- For each pixel, sweeps the dictionary at one entry per cycle and emits the squared Euclidean distance plus the entry index, then the end-of-sweep flags; after knn pixels it raises knn_fin.

Parameters:
- knn, 4: pixels per classification block (1..63).
- color_num, 5: dictionary entries (2..8, fits m[2:0]).

Ports:
- clk_en  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a new block.
- dic_wr_en  input  1  dictionary write strobe.
- dic_wr_addr  input  3  dictionary entry index.
- dic_wr_data  input  16  RGB565 colour {R[15:11],G[10:5],B[4:0]}.
- pix_valid  input  1  pixel present.
- pix_data  input  16  RGB565 pixel.
- pix_ready  output  1  pixel accepted when pix_valid & pix_ready.
- distance  output  14  squared distance, registered.
- m  output  3  dictionary index of distance, registered.
- dic_go  output  1  sweep active.
- dic_end  output  1  sweep finished.
- dic_end_q  output  1  dic_end delayed one cycle.
- knn_fin  output  1  block complete, level.
- busy  output  1  state is not IDLE and not DONE.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, pixel counter 0, state IDLE; dictionary entries cleared to 0x0000. Reset mid-sweep aborts immediately; no partial flags are emitted after release.
- Dictionary: written on a clock edge when dic_wr_en=1 and state is IDLE or DONE.
  - Writes in any other state are dropped.
  - dic_wr_addr >= color_num is dropped.
- Distance: dR=|R_p-R_k| (5b), dG=|G_p-G_k| (6b), dB=|B_p-B_k| (5b); distance = dR^2+dG^2+dB^2, unsigned. Maximum value 961+3969+961 = 5891 < 2^14, so there is no saturation.
- FSM states, with transitions:
  - IDLE: start -> WAIT_PIX.
  - WAIT_PIX: pix_ready=1. On handshake, latch pixel -> SWEEP with k=0.
  - SWEEP: dic_go=1, m=k, distance=d(pixel, dict[k]); k increments each cycle. When k=color_num-1 -> END_A.
  - END_A: dic_go=1, dic_end=1, dic_end_q=0; m and distance hold their last values -> END_B.
  - END_B: dic_go=1, dic_end=1, dic_end_q=1 (exactly one cycle with both high); m and distance hold -> GAP.
  - GAP: dic_go=0, dic_end=0, dic_end_q=0, m=0, distance=0. Pixel counter increments. If count==knn -> DONE, else -> WAIT_PIX.
  - DONE: knn_fin=1, held. start -> clear knn_fin and counter -> WAIT_PIX. knn_fin must stay high at least color_num+2 cycles (the downstream max scan). start earlier than that is ignored.
- Latency: pixel handshake at edge T gives m=0 at T+1. One pixel occupies color_num+3 cycles. A block takes knn*(color_num+3) cycles plus any pixel wait time.
- start in WAIT_PIX/SWEEP/END/GAP is ignored.
- pix_valid outside WAIT_PIX is ignored; pix_ready=0 there.
- start and dic_wr_en in the same IDLE cycle: both take effect, and the write is visible to the first sweep.
- pix_valid may stall arbitrarily in WAIT_PIX; outputs idle at GAP values meanwhile.

Test Plan:
- Dictionary {0x0000,0xFFFF,0xF800,0x07E0,0x001F}, start, pixel 0xF800 -> m=0..4 on consecutive cycles, distance=961,4930,0,4930,1922; then END_A/END_B flags; then dic_go=0.
- Pixel 0x0000 vs entry 0xFFFF -> distance=5891 (no overflow); pixel 0xFFFF vs entry 0xFFFF -> 0.
- Four pixels with pix_valid gaps of 0 and 3 cycles -> exactly 4 sweeps; knn_fin rises one cycle after the 4th GAP; dic_end&dic_end_q high exactly 4 cycles total.
- Write dic_wr_en mid-sweep (addr 2, 0x1234) -> dictionary unchanged; next sweep still gives the old entry-2 distance. start during SWEEP -> ignored.
- reset_n low in SWEEP at k=2 -> all outputs 0 asynchronously; after release, state IDLE and dictionary cleared (all distances equal |pixel|^2).
- DONE, then start after 7 cycles -> knn_fin falls, pix_ready=1 next cycle; new block counts from 0.
